// File: rtl/onewire_byte_reader.sv
// 1-Wire read sequencer: issues NUM_BYTES*8 read slots and assembles LSB-first bytes onto a valid/ready stream.
// Optional Dallas CRC-8 check over the whole transfer with `define ONEWIRE_CRC8_EN (adds crc_ok port).
module onewire_byte_reader #(
  parameter int NUM_BYTES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       bit_start,
  input  logic       bit_done,
  input  logic       bit_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       done
`ifdef ONEWIRE_CRC8_EN
  ,
  output logic       crc_ok
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_PUSH} state_t;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_byte_cnt;
  logic [7:0] r_sr;
  logic [7:0] r_byte_data;
  logic       r_busy, r_bit_start, r_byte_valid, r_done;

  logic [7:0] w_sr_nxt;
  logic       w_last_byte, w_bit_take, w_start_take;

  assign w_sr_nxt     = {bit_in, r_sr[7:1]};
  assign w_last_byte  = (r_byte_cnt == 8'(NUM_BYTES - 1));
  // A bit_done coinciding with our own bit_start belongs to an earlier slot.
  assign w_bit_take   = (r_state == S_WAIT) && bit_done && !r_bit_start;
  assign w_start_take = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_sr         <= '0;
      r_byte_data  <= '0;
      r_busy       <= 1'b0;
      r_bit_start  <= 1'b0;
      r_byte_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_bit_start <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: if (w_start_take) begin
          r_busy     <= 1'b1;
          r_bit_cnt  <= '0;
          r_byte_cnt <= '0;
          r_state    <= S_REQ;
        end
        S_REQ: begin
          r_bit_start <= 1'b1;
          r_state     <= S_WAIT;
        end
        S_WAIT: if (w_bit_take) begin
          r_sr      <= w_sr_nxt;
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_byte_data  <= w_sr_nxt;
            r_byte_valid <= 1'b1;
            r_state      <= S_PUSH;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_PUSH: if (r_byte_valid && byte_ready) begin
          r_byte_valid <= 1'b0;
          if (w_last_byte) begin
            r_byte_cnt <= '0;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_byte_cnt <= r_byte_cnt + 8'd1;
            r_state    <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign bit_start  = r_bit_start;
  assign byte_data  = r_byte_data;
  assign byte_valid = r_byte_valid;
  assign done       = r_done;

`ifdef ONEWIRE_CRC8_EN
  logic [7:0] r_crc, w_crc_nxt;
  logic       r_crc_ok, w_fb;

  // Reflected x^8+x^5+x^4+1, one bit per accepted slot result.
  assign w_fb      = r_crc[0] ^ bit_in;
  assign w_crc_nxt = (r_crc >> 1) ^ (w_fb ? 8'h8C : 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc    <= '0;
      r_crc_ok <= 1'b0;
    end else if (w_start_take) begin
      r_crc    <= '0;
      r_crc_ok <= 1'b0;
    end else if (w_bit_take) begin
      r_crc <= w_crc_nxt;
      if (r_bit_cnt == 3'd7 && w_last_byte) r_crc_ok <= (w_crc_nxt == 8'h00);
    end
  end

  assign crc_ok = r_crc_ok;
`endif

endmodule

// File: tb/tb_onewire_byte_reader.sv
// Directed bench for onewire_byte_reader: NUM_BYTES=1 and 2 instances, plus NUM_BYTES=8 with CRC when enabled.
module tb_onewire_byte_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start_v = 1'b0, bit_done = 1'b0, bit_in = 1'b0, byte_ready = 1'b0;
  int   sel = 0;

  logic st0, st1, busy0, busy1, bs0, bs1, bv0, bv1, dn0, dn1;
  logic [7:0] bd0, bd1;
  logic busy_m, bs_m, bv_m, dn_m, crc_m;
  logic [7:0] bd_m;

  assign st0 = start_v && (sel == 0);
  assign st1 = start_v && (sel == 1);

  onewire_byte_reader #(.NUM_BYTES(1)) u1 (
    .clk(clk), .rst(rst), .start(st0), .busy(busy0), .bit_start(bs0),
    .bit_done(bit_done), .bit_in(bit_in), .byte_data(bd0), .byte_valid(bv0),
    .byte_ready(byte_ready), .done(dn0)
`ifdef ONEWIRE_CRC8_EN
    , .crc_ok()
`endif
  );

  onewire_byte_reader #(.NUM_BYTES(2)) u2 (
    .clk(clk), .rst(rst), .start(st1), .busy(busy1), .bit_start(bs1),
    .bit_done(bit_done), .bit_in(bit_in), .byte_data(bd1), .byte_valid(bv1),
    .byte_ready(byte_ready), .done(dn1)
`ifdef ONEWIRE_CRC8_EN
    , .crc_ok()
`endif
  );

`ifdef ONEWIRE_CRC8_EN
  logic st2, busy2, bs2, bv2, dn2, crc2;
  logic [7:0] bd2;
  assign st2 = start_v && (sel == 2);
  onewire_byte_reader #(.NUM_BYTES(8)) u8 (
    .clk(clk), .rst(rst), .start(st2), .busy(busy2), .bit_start(bs2),
    .bit_done(bit_done), .bit_in(bit_in), .byte_data(bd2), .byte_valid(bv2),
    .byte_ready(byte_ready), .done(dn2), .crc_ok(crc2)
  );
`endif

  always_comb begin
    busy_m = busy0; bs_m = bs0; bv_m = bv0; dn_m = dn0; bd_m = bd0; crc_m = 1'b0;
    if (sel == 1) begin
      busy_m = busy1; bs_m = bs1; bv_m = bv1; dn_m = dn1; bd_m = bd1;
    end
`ifdef ONEWIRE_CRC8_EN
    if (sel == 2) begin
      busy_m = busy2; bs_m = bs2; bv_m = bv2; dn_m = dn2; bd_m = bd2; crc_m = crc2;
    end
`endif
  end

  int n_pass = 0, n_tot = 0;
  int n_bs = 0, n_dn = 0;
  // seq[b][7] is the first bit on the wire for byte b; expb[b] is the byte that should come out.
  logic [7:0] seq  [16];
  logic [7:0] expb [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
    if (bs_m) n_bs++;
    if (dn_m) n_dn++;
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = v[7-k];
    return r;
  endfunction

  // stall_byte: byte index held 20 cycles with byte_ready low (-1 none); spur: poke start/bit_done
  // during that stall; abort_bit: reset the design while this slot of byte 0 is being requested.
  task automatic do_txn(input int nb, input int stall_byte, input bit spur, input int abort_bit);
    int t;
    int bs_before;
    start_v = 1'b1;
    tick();
    start_v = 1'b0;
    chk("busy_after_start", busy_m, 1);
    if (sel == 2) chk("crc_ok_cleared_on_start", crc_m, 0);
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 8; i++) begin
        t = 0;
        while (!bs_m && t < 50) begin tick(); t++; end
        if (!bs_m) begin chk("bit_start_timeout", 0, 1); return; end
        if (b == 0 && i == 0) chk("start_to_bit_start_latency", t, 1);
        if (b == 0 && i == abort_bit) begin
          rst = 1'b1;
          #1;
          chk("abort_busy", busy_m, 0);
          chk("abort_bit_start", bs_m, 0);
          chk("abort_byte_valid", bv_m, 0);
          chk("abort_byte_data", bd_m, 0);
          chk("abort_done", dn_m, 0);
          tick();
          rst = 1'b0;
          return;
        end
        tick();
        bit_done = 1'b1;
        bit_in   = seq[b][7-i];
        tick();
        bit_done = 1'b0;
        bit_in   = 1'b0;
      end
      chk("byte_valid", bv_m, 1);
      chk("byte_data", bd_m, expb[b]);
      if (b == stall_byte) begin
        bs_before = n_bs;
        for (int c = 0; c < 20; c++) begin
          if (spur && c == 5) begin start_v = 1'b1; bit_done = 1'b1; bit_in = ~bd_m[0]; end
          tick();
          start_v = 1'b0; bit_done = 1'b0; bit_in = 1'b0;
        end
        chk("stall_no_bit_start", n_bs - bs_before, 0);
        chk("stall_data_stable", bd_m, expb[b]);
        chk("stall_valid_held", bv_m, 1);
        chk("stall_busy", busy_m, 1);
      end
      byte_ready = 1'b1;
      tick();
      byte_ready = 1'b0;
      chk("valid_drops_on_accept", bv_m, 0);
      chk("done_on_last_accept", dn_m, (b == nb - 1) ? 1 : 0);
      if (b == nb - 1) chk("busy_low_at_done", busy_m, 0);
    end
  endtask

  typedef struct {
    logic [7:0] seq;   // time-ordered wire bits, MSB first on the wire
    logic [7:0] exp;   // hand-computed LSB-first assembly
  } vec_t;

  vec_t tbl [6];
  logic [7:0] rom [8];
  int bs0_cnt, dn0_cnt;

  initial begin
    tbl[0] = '{8'b1011_0010, 8'h4D};
    tbl[1] = '{8'b1000_0000, 8'h01};
    tbl[2] = '{8'b0000_0001, 8'h80};
    tbl[3] = '{8'b1111_0000, 8'h0F};
    tbl[4] = '{8'b1100_1010, 8'h53};
    tbl[5] = '{8'b0000_0000, 8'h00};

    tick(); tick();
    chk("reset_busy", busy_m, 0);
    chk("reset_bit_start", bs_m, 0);
    chk("reset_byte_valid", bv_m, 0);
    chk("reset_byte_data", bd_m, 0);
    chk("reset_done", dn_m, 0);
    rst = 1'b0;
    // byte_ready with nothing valid must not disturb the idle block
    byte_ready = 1'b1; tick(); byte_ready = 1'b0;
    chk("ready_without_valid", bv_m, 0);

    sel = 0;
    for (int v = 0; v < 6; v++) begin
      seq[0]  = tbl[v].seq;
      expb[0] = tbl[v].exp;
      bs0_cnt = n_bs; dn0_cnt = n_dn;
      do_txn(1, -1, 1'b0, -1);
      tick();
      chk("bit_start_pulses", n_bs - bs0_cnt, 8);
      chk("done_pulses", n_dn - dn0_cnt, 1);
    end

    // reset during the 4th slot, then a clean read
    seq[0] = 8'b1011_0010; expb[0] = 8'h4D;
    do_txn(1, -1, 1'b0, 3);
    do_txn(1, -1, 1'b0, -1);

    // two bytes, stall after first with spurious start and bit_done
    sel = 1;
    seq[0] = 8'b1100_1010; expb[0] = 8'h53;
    seq[1] = 8'b0111_1111; expb[1] = 8'hFE;
    bs0_cnt = n_bs; dn0_cnt = n_dn;
    do_txn(2, 0, 1'b1, -1);
    tick();
    chk("two_byte_bit_starts", n_bs - bs0_cnt, 16);
    chk("two_byte_done_pulses", n_dn - dn0_cnt, 1);
    // back-to-back without the extra idle cycle
    do_txn(2, -1, 1'b0, -1);
    do_txn(2, -1, 1'b0, -1);

`ifdef ONEWIRE_CRC8_EN
    sel = 2;
    rom = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2};
    for (int b = 0; b < 8; b++) begin seq[b] = rev8(rom[b]); expb[b] = rom[b]; end
    do_txn(8, -1, 1'b0, -1);
    chk("crc_ok_good", crc_m, 1);
    seq[7] = rev8(8'hA3); expb[7] = 8'hA3;
    do_txn(8, -1, 1'b0, -1);
    chk("crc_ok_bad", crc_m, 0);
    seq[7] = rev8(8'hA2); expb[7] = 8'hA2;
    do_txn(8, -1, 1'b0, -1);
    chk("crc_ok_independent", crc_m, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
